// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MEM stage controller.
//               - branch-type encodings as carried on ex_branch_type
//               - data-memory handshake FSM state encoding
//               - default datapath / register-index widths
//               - small helper for word-alignment detection
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // Default widths; blocks take these as parameter defaults
  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  // Branch type encodings; any value not listed behaves as BR_NONE
  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b001;
  localparam logic [2:0] BR_NE   = 3'b010;
  localparam logic [2:0] BR_LT   = 3'b011;
  localparam logic [2:0] BR_GT   = 3'b100;

  // Data-memory handshake state
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // True when the two low address bits do not describe a word boundary
  function automatic logic is_unaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl_if
// Description : Data-memory request/ready bus between the MEM stage and the
//               data memory.
//               master (MEM stage): drives req, we, addr, wdata
//                                   samples ready, rdata
//               slave  (memory)   : the reverse
//               req/we/addr/wdata stay stable while req=1 and ready=0;
//               rdata is valid only in a cycle with ready=1.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_ctrl_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ready,
    output rdata
  );

endinterface : mem_stage_ctrl_if
`default_nettype wire

// File: rtl/mem_stage_ctrl_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve
// Description : Purely combinational branch-condition evaluation from the
//               latched branch type and ALU compare flags. The caller
//               qualifies the result with the instruction's valid bit.
// Ports       : branch_type in  3  BR_* encoding (unknown codes -> no branch)
//               zero        in  1  ALU result was zero
//               lt          in  1  ALU signed less-than
//               gt          in  1  ALU signed greater-than
//               cond        out 1  branch condition holds
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve
  import mips_pkg::*;
(
  input  logic [2:0] branch_type,
  input  logic       zero,
  input  logic       lt,
  input  logic       gt,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (branch_type)
      BR_EQ:   cond = zero;
      BR_NE:   cond = ~zero;
      BR_LT:   cond = lt;
      BR_GT:   cond = gt;
      default: cond = 1'b0;
    endcase
  end

endmodule : branch_resolve
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM pipeline stage controller.
//               - EX/MEM register capturing the execute-stage outputs
//               - branch resolution from the latched compare flags
//               - req/ready handshake with data memory, stalling the
//                 pipeline while an access is outstanding
//               - registered MEM/WB result towards write-back
// Ports       : clk, rst              clock, async active-high reset
//               ex_*                  execute-stage outputs (instruction)
//               flush                 turn the next capture into a bubble
//               stall_out             EX and earlier stages must hold
//               branch_taken/_target  resolved branch of EX/MEM instruction
//               misalign              EX/MEM load/store is not word aligned
//               dmem                  data-memory bus (master side)
//               wb_*                  MEM/WB register outputs
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_add_result,
  input  logic [DATA_W-1:0] ex_second_read_data,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic              ex_zero,
  input  logic              ex_lt,
  input  logic              ex_gt,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic              ex_reg_write,
  input  logic              ex_mem_to_reg,
  input  logic [2:0]        ex_branch_type,
  input  logic              flush,

  output logic              stall_out,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_target,
  output logic              misalign,

  mem_stage_ctrl_if.master  dmem,

  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_write_reg,
  output logic [DATA_W-1:0] wb_data
);

  // --------------------------------------------------------------------------
  // EX/MEM pipeline register
  // --------------------------------------------------------------------------
  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_alu_result;
  logic [DATA_W-1:0] r_m_add_result;
  logic [DATA_W-1:0] r_m_store_data;
  logic [REG_W-1:0]  r_m_write_reg;
  logic              r_m_zero;
  logic              r_m_lt;
  logic              r_m_gt;
  logic              r_m_mem_read;
  logic              r_m_mem_write;
  logic              r_m_reg_write;
  logic              r_m_mem_to_reg;
  logic [2:0]        r_m_branch_type;

  // MEM/WB pipeline register
  logic              r_wb_valid;
  logic              r_wb_reg_write;
  logic [REG_W-1:0]  r_wb_write_reg;
  logic [DATA_W-1:0] r_wb_data;

  // Handshake FSM
  mem_state_e        r_state;
  mem_state_e        w_state_nxt;

  // Derived combinational terms
  logic              w_mem_access;
  logic              w_misalign;
  logic              w_mem_op;
  logic              w_stall;
  logic              w_req;
  logic              w_we;
  logic              w_cond;

  // A load/store that is not word aligned is dropped from the memory
  // interface entirely: it neither requests nor stalls, and retires
  // without a register write.
  assign w_mem_access = r_m_valid & (r_m_mem_read | r_m_mem_write);
  assign w_misalign   = w_mem_access & is_unaligned(r_m_alu_result[1:0]);
  assign w_mem_op     = w_mem_access & ~w_misalign;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid       <= 1'b0;
      r_m_alu_result  <= '0;
      r_m_add_result  <= '0;
      r_m_store_data  <= '0;
      r_m_write_reg   <= '0;
      r_m_zero        <= 1'b0;
      r_m_lt          <= 1'b0;
      r_m_gt          <= 1'b0;
      r_m_mem_read    <= 1'b0;
      r_m_mem_write   <= 1'b0;
      r_m_reg_write   <= 1'b0;
      r_m_mem_to_reg  <= 1'b0;
      r_m_branch_type <= BR_NONE;
    end else if (!w_stall) begin
      // A flush during a stall is deliberately ignored here; upstream keeps
      // flush asserted until the stall clears so it lands on this capture.
      r_m_valid       <= ex_valid & ~flush;
      r_m_alu_result  <= ex_alu_result;
      r_m_add_result  <= ex_add_result;
      r_m_store_data  <= ex_second_read_data;
      r_m_write_reg   <= ex_write_reg;
      r_m_zero        <= ex_zero;
      r_m_lt          <= ex_lt;
      r_m_gt          <= ex_gt;
      r_m_mem_read    <= ex_mem_read;
      r_m_mem_write   <= ex_mem_write;
      r_m_reg_write   <= ex_reg_write;
      r_m_mem_to_reg  <= ex_mem_to_reg;
      r_m_branch_type <= ex_branch_type;
    end
  end

  // --------------------------------------------------------------------------
  // Data-memory handshake FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The request is a pure function of the held EX/MEM contents, so while
  // the stall freezes EX/MEM the request, address, data and write enable
  // remain stable across the whole WAIT period. The state records whether
  // an access is outstanding across an edge.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_we        = 1'b0;
    w_stall     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_req   = w_mem_op;
        w_we    = w_mem_op & r_m_mem_write;
        w_stall = w_mem_op & ~dmem.ready;
        if (w_mem_op && !dmem.ready) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_req   = w_mem_op;
        w_we    = w_mem_op & r_m_mem_write;
        w_stall = w_mem_op & ~dmem.ready;
        if (dmem.ready || !w_mem_op) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Word address: low bits are masked so the memory only ever sees
  // word-aligned addresses.
  assign dmem.req   = w_req;
  assign dmem.we    = w_we;
  assign dmem.addr  = {r_m_alu_result[DATA_W-1:2], 2'b00};
  assign dmem.wdata = r_m_store_data;

  assign stall_out  = w_stall;
  assign misalign   = w_misalign;

  // --------------------------------------------------------------------------
  // Branch resolution
  // --------------------------------------------------------------------------
  branch_resolve u_branch_resolve (
    .branch_type (r_m_branch_type),
    .zero        (r_m_zero),
    .lt          (r_m_lt),
    .gt          (r_m_gt),
    .cond        (w_cond)
  );

  assign branch_taken  = r_m_valid & w_cond;
  assign branch_target = r_m_add_result;

  // --------------------------------------------------------------------------
  // MEM/WB pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
      r_wb_write_reg <= '0;
      r_wb_data      <= '0;
    end else if (w_stall) begin
      // Instruction is still waiting on memory: hand write-back a bubble.
      r_wb_valid     <= 1'b0;
      r_wb_reg_write <= 1'b0;
    end else begin
      r_wb_valid     <= r_m_valid;
      r_wb_reg_write <= r_m_reg_write & r_m_valid & ~w_misalign;
      r_wb_write_reg <= r_m_write_reg;
      r_wb_data      <= r_m_mem_to_reg ? dmem.rdata : r_m_alu_result;
    end
  end

  assign wb_valid     = r_wb_valid;
  assign wb_reg_write = r_wb_reg_write;
  assign wb_write_reg = r_wb_write_reg;
  assign wb_data      = r_wb_data;

endmodule : mem_stage_ctrl
`default_nettype wire

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Consumer end of the execute-stage output interface: captures ALU result, branch target, store data, destination register and compare flags into the EX/MEM pipeline register.
- Resolves conditional branches from the latched flags.
- Runs a req/ready handshake with data memory and holds the pipeline while an access is outstanding.
- Drives a registered MEM/WB result towards write-back.

Parameters:
DATA_W, 32, datapath width (ALU result, addresses, memory data)
REG_W, 5, register-file index width

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
ex_valid  in  1  EX outputs hold a real instruction
ex_alu_result  in  DATA_W  ALU result; memory address for loads and stores
ex_add_result  in  DATA_W  branch target (PC+4 + offset<<2)
ex_second_read_data  in  DATA_W  store data
ex_write_reg  in  REG_W  destination register
ex_zero, ex_lt, ex_gt  in  1 each  ALU compare flags
ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  in  1 each  control bits
ex_branch_type  in  3  000 none, 001 beq, 010 bne, 011 blt, 100 bgt, others none
flush  in  1  replace the next captured instruction with a bubble
stall_out  out  1  EX and earlier stages must hold
branch_taken  out  1  latched branch condition true
branch_target  out  DATA_W  latched ex_add_result
dmem_req, dmem_we  out  1 each  memory request, write enable
dmem_addr, dmem_wdata  out  DATA_W  word address, store data
dmem_ready  in  1  access completes this cycle
dmem_rdata  in  DATA_W  load data, valid when dmem_ready=1
misalign  out  1  latched load/store address has addr[1:0]!=0
wb_valid, wb_reg_write  out  1 each  MEM/WB valid, register write enable
wb_write_reg  out  REG_W  write-back destination
wb_data  out  DATA_W  dmem_rdata if mem_to_reg, else ALU result

Behaviour:
- Reset (async, immediate): EX/MEM and MEM/WB registers cleared (valid=0, data 0); FSM to IDLE. All outputs 0.
- EX/MEM capture: each rising edge with stall_out=0 loads every ex_* field.
  - The captured valid is ex_valid & ~flush.
  - flush while stall_out=1 has no effect; upstream holds flush until the stall clears.
- mem_op = m_valid & (m_mem_read | m_mem_write) & ~misalign.
- Misaligned access: suppressed (no dmem_req, no stall). The instruction retires with wb_reg_write=0. misalign is high for the cycle the instruction sits in EX/MEM.
- FSM states: IDLE, WAIT.
  - IDLE: dmem_req=mem_op. If dmem_ready=1 the access completes the same cycle. If dmem_ready=0, go to WAIT.
  - WAIT: hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable. Return to IDLE on dmem_ready=1.
  - dmem_we=m_mem_write. If both m_mem_read and m_mem_write are set, the write wins.
- stall_out = mem_op & ~dmem_ready (combinational). Stall length equals the number of memory wait cycles.
- MEM/WB: loads at each edge with stall_out=0.
  - wb_valid=m_valid.
  - wb_reg_write=m_reg_write & m_valid & ~misalign.
  - While stalled, a bubble enters MEM/WB (wb_valid=0).
- Latency: ex_valid accepted at edge N gives wb_valid at edge N+1, plus W extra cycles for W memory wait cycles.
- Branch resolution (combinational from EX/MEM):
  - branch_taken = m_valid & cond, with cond = zero (beq), ~zero (bne), lt (blt), gt (bgt).
  - Branches never stall.
  - Flushing younger instructions is the hazard unit's job via flush.
- Reset mid-access: request dropped immediately. The memory model must tolerate dmem_req falling without dmem_ready.
- dmem_addr = m_alu_result with bits [1:0] forced to 0.

Decomposition:
- Shared package (mips_pkg):
  - branch-type constants: BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GT.
  - FSM state encoding.
  - DATA_W and REG_W defaults.
- One natural sub-module, branch_resolve: combinational cond from branch type and flags.
- The EX/MEM register, FSM and MEM/WB register stay in this block.

Test Plan:
1. ALU op, reg_write=1, ex_alu_result=0x00000010, write_reg=9 -> two edges later wb_valid=1, wb_data=0x10, wb_write_reg=9, no dmem_req.
2. Load, addr 0x100, dmem_ready low 3 cycles then high with rdata 0xDEADBEEF -> stall_out high 3 cycles, addr and req stable, then wb_data=0xDEADBEEF.
3. Store, addr 0x20, data 0x55 with dmem_ready=1 immediately -> one cycle dmem_req=1, dmem_we=1, wdata=0x55, stall_out=0, wb_reg_write=0.
4. beq with zero=1, target 0x400 -> branch_taken=1, branch_target=0x400. bne with zero=1 -> 0. blt with lt=1 -> 1. bgt with gt=0 -> 0.
5. Load at 0x103 -> misalign=1, no dmem_req, wb_reg_write=0. flush with ex_valid=1 -> captured bubble, wb_valid=0 next cycle.
6. Assert rst during WAIT -> dmem_req, stall_out, wb_valid all 0 immediately. After release, a fresh load completes normally.
